// File: rtl/program_loader.sv
// program_loader: receives a program as a byte stream and writes it into
// instruction memory one little-endian 32-bit word at a time.
// The RISC-V core is held while a load is in progress.
// Optional build macro: LOADER_CHECKSUM_EN -- when defined, the loader
// expects one extra byte after the last word. The load is flagged as bad
// unless that byte plus the mod-256 sum of all program bytes equals zero.
//
// Byte handshake: byte_ready_o depends only on the current state.
// A byte is taken on the rising edge where byte_valid_i and byte_ready_o
// are both 1. The sender must hold byte_data_i steady while byte_valid_i=1.
// No combinational path runs from byte_valid_i to byte_ready_o.
module program_loader #(
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(32'h0040_0000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [15:0]           length_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  core_hold_o,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECEIVE = 3'd1,
        S_WRITE   = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_length;      // word count latched when a start is accepted
    logic [15:0] r_word_idx;    // index of the word being assembled or written
    logic [1:0]  r_byte_idx;    // byte lane the next accepted byte fills
    logic [31:0] r_word;        // word under assembly
    logic        r_error;

    logic        w_start_ok;
    logic        w_accept;
    logic        w_len_zero;
    logic        w_len_over;
    logic [15:0] w_word_idx_inc;
    logic        w_last_word;
    logic [DATA_WIDTH-1:0] w_word_offset;

    // A start is only honoured when no load is in flight.
    assign w_start_ok     = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept       = byte_valid_i && byte_ready_o;
    assign w_len_zero     = (length_i == 16'd0);
    assign w_len_over     = ({16'd0, length_i} > MEMORY_DEPTH);
    assign w_word_idx_inc = r_word_idx + 16'd1;
    assign w_last_word    = (w_word_idx_inc == r_length);
    assign w_word_offset  = DATA_WIDTH'({r_word_idx, 2'b00});

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_total;

    assign w_sum_total = byte_data_i + r_sum;

    // Running mod-256 sum of every accepted program byte of the current load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= 8'd0;
        end else if (w_start_ok) begin
            r_sum <= 8'd0;
        end else if ((r_state == S_RECEIVE) && w_accept) begin
            r_sum <= w_sum_total;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Degenerate lengths skip straight to DONE without a write.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    if (w_len_zero || w_len_over) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_RECEIVE;
                    end
                end
            end
            S_RECEIVE: begin
                if (w_accept && (r_byte_idx == 2'd3)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next_state = S_CHECK;
`else
                    w_next_state = S_DONE;
`endif
                end else begin
                    w_next_state = S_RECEIVE;
                end
            end
            S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_accept) begin
                    w_next_state = S_DONE;
                end
`else
                w_next_state = S_DONE;
`endif
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch the load request, assemble bytes, advance the word index, track errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_length   <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
            r_error    <= 1'b0;
        end else if (w_start_ok) begin
            r_length   <= length_i;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
            r_error    <= w_len_over;
        end else begin
            case (r_state)
                S_RECEIVE: begin
                    if (w_accept) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= byte_data_i;
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_idx <= w_word_idx_inc;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_error <= (w_sum_total != 8'h00);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from state. The memory bus is driven only during the write strobe.
`ifdef LOADER_CHECKSUM_EN
    assign byte_ready_o  = (r_state == S_RECEIVE) || (r_state == S_CHECK);
`else
    assign byte_ready_o  = (r_state == S_RECEIVE);
`endif
    assign mem_we_o      = (r_state == S_WRITE);
    assign mem_address_o = mem_we_o ? (BASE_ADDRESS + w_word_offset) : '0;
    assign mem_data_o    = mem_we_o ? DATA_WIDTH'(r_word) : '0;
    assign busy_o        = (r_state == S_RECEIVE) || (r_state == S_WRITE) || (r_state == S_CHECK);
    assign core_hold_o   = busy_o;
    assign done_o        = (r_state == S_DONE);
    assign error_o       = r_error;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. A behavioural model builds each expected
// memory write from the byte list: word w holds bytes 4w..4w+3,
// little-endian, at BASE + 4w. A negedge monitor checks every write strobe
// against those expected writes.
module tb_program_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [15:0] length_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic        core_hold_o;
    logic [2:0]  dbg_state_o;

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    program_loader #(
        .MEMORY_DEPTH(DEPTH),
        .DATA_WIDTH  (32),
        .BASE_ADDRESS(BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .length_i     (length_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_address_o(mem_address_o),
        .mem_data_o   (mem_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .core_hold_o  (core_hold_o),
        .dbg_state_o  (dbg_state_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    logic [63:0] exp_q[$];      // expected {address, data} writes
    logic [63:0] got_q[$];      // observed writes of the current load
    logic [7:0]  bq[$];         // bytes still to be sent
    logic [7:0]  load_bytes[$]; // program bytes of the current load

    typedef struct {
        logic [15:0] len;
        bit          toggle;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: each write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we_o === 1'b1) begin
            n_writes++;
            got_q.push_back({mem_address_o, mem_data_o});
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got %h required no write", {mem_address_o, mem_data_o});
            end else begin
                check("write", {mem_address_o, mem_data_o}, exp_q.pop_front());
            end
        end
    end

    task automatic fill_random(input logic [15:0] len);
        load_bytes.delete();
        if (int'(len) <= DEPTH) begin
            for (int i = 0; i < 4 * int'(len); i++) load_bytes.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic start_load(input logic [15:0] len);
        @(negedge clk);
        start_i  = 1'b1;
        length_i = len;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    // Send the bytes in bq. Valid is either random or toggles every cycle.
    // A start pulse with length 1 can be injected at cycle pulse_at.
    task automatic drive_bytes(input bit toggle, input int pulse_at, input int budget);
        int cyc   = 0;
        bit phase = 1'b1;
        while (bq.size() > 0 && cyc < budget) begin
            @(negedge clk);
            start_i      = (cyc == pulse_at);
            if (cyc == pulse_at) length_i = 16'd1;
            byte_valid_i = toggle ? phase : ($urandom_range(0, 3) != 0);
            phase        = ~phase;
            byte_data_i  = bq[0];
            if (byte_valid_i && byte_ready_o) void'(bq.pop_front());
            cyc++;
        end
        check("bytes_drained", 64'(bq.size()), 64'd0);
        @(negedge clk);
        byte_valid_i = 1'b0;
        byte_data_i  = 8'd0;
        start_i      = 1'b0;
    endtask

    // Run one load of load_bytes and check completion status.
    task automatic do_load(input string tag, input logic [15:0] len, input bit toggle,
                           input int pulse_at, input bit bad_sum, input bit exp_err,
                           input int exp_writes);
        int          sum = 0;
        int          c   = 0;
        bit          valid_len;
        logic [31:0] word;
        valid_len = (len != 16'd0) && (int'(len) <= DEPTH);
        bq.delete();
        got_q.delete();
        n_writes = 0;
        if (valid_len) begin
            for (int w = 0; w < int'(len); w++) begin
                word = 32'd0;
                for (int k = 0; k < 4; k++) word = word | (32'(load_bytes[4 * w + k]) << (8 * k));
                exp_q.push_back({BASE + 32'(4 * w), word});
            end
            foreach (load_bytes[i]) begin
                bq.push_back(load_bytes[i]);
                sum += int'(load_bytes[i]);
            end
`ifdef LOADER_CHECKSUM_EN
            bq.push_back(8'((256 - (sum % 256)) % 256) ^ {7'd0, bad_sum});
`else
            if (bad_sum) $display("note: checksum corruption has no effect in this build");
`endif
        end
        start_load(len);
        if (valid_len) begin
            check({tag, "_busy"}, 64'(busy_o), 64'd1);
            check({tag, "_hold"}, 64'(core_hold_o), 64'd1);
        end else begin
            check({tag, "_done_next"}, 64'(done_o), 64'd1);
            check({tag, "_err_next"}, 64'(error_o), 64'(exp_err));
        end
        drive_bytes(toggle, pulse_at, 4000);
        while (done_o !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done"}, 64'(done_o), 64'd1);
        check({tag, "_error"}, 64'(error_o), 64'(exp_err));
        check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_idle_hold"}, 64'(core_hold_o), 64'd0);
        check({tag, "_nwrites"}, 64'(n_writes), 64'(exp_writes));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_hold"}, 64'(core_hold_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_error"}, 64'(error_o), 64'd0);
        check({tag, "_we"}, 64'(mem_we_o), 64'd0);
        check({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
        check({tag, "_addr"}, 64'(mem_address_o), 64'd0);
        check({tag, "_data"}, 64'(mem_data_o), 64'd0);
    endtask

    initial begin
        logic [15:0] rlen;
        bit          rtog;

        vecs[0] = '{len: 16'd0,      toggle: 1'b0, exp_err: 1'b0, exp_writes: 0};
        vecs[1] = '{len: 16'd1,      toggle: 1'b1, exp_err: 1'b0, exp_writes: 1};
        vecs[2] = '{len: 16'd2,      toggle: 1'b0, exp_err: 1'b0, exp_writes: 2};
        vecs[3] = '{len: 16'd33,     toggle: 1'b0, exp_err: 1'b1, exp_writes: 0};
        vecs[4] = '{len: 16'd5,      toggle: 1'b0, exp_err: 1'b0, exp_writes: 5};
        vecs[5] = '{len: 16'd32,     toggle: 1'b0, exp_err: 1'b0, exp_writes: 32};
        vecs[6] = '{len: 16'hFFFF,   toggle: 1'b0, exp_err: 1'b1, exp_writes: 0};
        vecs[7] = '{len: 16'd3,      toggle: 1'b1, exp_err: 1'b0, exp_writes: 3};

        reset        = 1'b0;
        start_i      = 1'b0;
        length_i     = 16'd0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Known two-instruction program.
        load_bytes = {8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_load("fixed", 16'd2, 1'b0, -1, 1'b0, 1'b0, 2);
        check("fixed_w0", got_q[0], {32'h0040_0000, 32'h0000_0513});
        check("fixed_w1", got_q[1], {32'h0040_0004, 32'h0010_0093});

        // Table of lengths, including zero, full depth and overflow.
        for (int i = 0; i < 8; i++) begin
            fill_random(vecs[i].len);
            do_load($sformatf("vec%0d", i), vecs[i].len, vecs[i].toggle, -1, 1'b0,
                    vecs[i].exp_err, vecs[i].exp_writes);
        end

        // Start pulse in the middle of a load must not disturb it.
        fill_random(16'd2);
        do_load("mid_start", 16'd2, 1'b0, 5, 1'b0, 1'b0, 2);

        // Reset after two bytes of word 0, then reload from scratch.
        fill_random(16'd1);
        bq.delete();
        bq.push_back(load_bytes[0]);
        bq.push_back(load_bytes[1]);
        start_load(16'd1);
        drive_bytes(1'b0, -1, 200);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        fill_random(16'd1);
        do_load("after_reset", 16'd1, 1'b0, -1, 1'b0, 1'b0, 1);
        check("after_reset_addr", 64'(got_q[0][63:32]), 64'h0040_0000);

        // Random lengths around the depth boundary.
        for (int i = 0; i < 12; i++) begin
            rlen = 16'($urandom_range(0, 36));
            rtog = 1'($urandom_range(0, 1));
            fill_random(rlen);
            do_load($sformatf("rand%0d", i), rlen, rtog, -1, 1'b0, (int'(rlen) > DEPTH),
                    (int'(rlen) > DEPTH) ? 0 : int'(rlen));
        end

`ifdef LOADER_CHECKSUM_EN
        // Bytes 01..04 sum to 0x0A: checksum 0xF6 is good, 0xF7 is bad.
        load_bytes = {8'h01, 8'h02, 8'h03, 8'h04};
        do_load("sum_good", 16'd1, 1'b0, -1, 1'b0, 1'b0, 1);
        load_bytes = {8'h01, 8'h02, 8'h03, 8'h04};
        do_load("sum_bad", 16'd1, 1'b0, -1, 1'b1, 1'b1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, meaning program memory size in 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning instruction/address width.
REQ-003 SHALL have parameter BASE_ADDRESS, default 32'h0040_0000, meaning byte address of word 0.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, one-cycle request to begin a load.
REQ-007 SHALL have port length_i, input, 16, number of words to load, sampled on accepted start_i.
REQ-008 SHALL have port byte_valid_i, input, 1, byte_data_i holds a valid byte.
REQ-009 SHALL have port byte_data_i, input, 8, incoming program byte.
REQ-010 SHALL have port byte_ready_o, output, 1, loader can accept a byte this cycle.
REQ-011 SHALL have port mem_we_o, output, 1, program memory write strobe.
REQ-012 SHALL have port mem_address_o, output, DATA_WIDTH, byte address of the word written.
REQ-013 SHALL have port mem_data_o, output, DATA_WIDTH, instruction word written.
REQ-014 SHALL have ports busy_o, done_o, error_o, output, 1 each: loading, load finished, load failed.
REQ-015 SHALL have port core_hold_o, output, 1, holds the RISC-V core stalled while busy_o=1.

Function
REQ-016 SHALL implement states IDLE, RECEIVE, WRITE, CHECK, DONE.
REQ-017 IDLE/DONE: start_i=1 SHALL latch length_i, clear word index, byte index, done_o, error_o; go RECEIVE.
REQ-018 start_i with length_i=0 SHALL go directly to DONE with done_o=1 and no write.
REQ-019 start_i with length_i>MEMORY_DEPTH SHALL go to DONE with error_o=1, done_o=1, no write.
REQ-020 start_i while in RECEIVE, WRITE or CHECK SHALL be ignored.
REQ-021 byte_ready_o SHALL be 1 only in RECEIVE (and CHECK with macro); a byte is accepted when byte_valid_i and byte_ready_o are both 1.
REQ-022 Accepted byte k (k=0..3) SHALL be placed at word bits [8k+7:8k] (little-endian).
REQ-023 After the 4th byte, next state SHALL be WRITE; mem_we_o=1 for exactly that one cycle; byte_ready_o=0.
REQ-024 mem_address_o SHALL equal BASE_ADDRESS + 4*word index, mem_data_o the assembled word, both stable while mem_we_o=1.
REQ-025 After WRITE, word index SHALL increment; if it equals latched length, go DONE (or CHECK with macro), else RECEIVE.
REQ-026 busy_o and core_hold_o SHALL be 1 in RECEIVE, WRITE, CHECK; 0 otherwise.
REQ-027 done_o SHALL stay 1 in DONE until the next accepted start_i.
REQ-028 mem_we_o SHALL never be 1 outside WRITE.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, all outputs 0, indices and assembled word cleared, regardless of clk.
REQ-030 Reset mid-load SHALL abandon the partial word with no further write; loaded words stay in memory.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of all accepted program bytes.
REQ-032 With it defined, after the last WRITE the FSM SHALL enter CHECK, accept one byte, and set error_o=1 if byte+sum != 8'h00; then DONE with done_o=1.
REQ-033 Without LOADER_CHECKSUM_EN, CHECK SHALL be unreachable, no checksum logic SHALL exist, and error_o SHALL only report length overflow.

Verification
REQ-034 Reset, start_i with length_i=2, bytes 13,05,00,00,93,00,10,00 -> writes 0x00000513@0x00400000, 0x00100093@0x00400004, then done_o=1.
REQ-035 byte_valid_i toggled 1/0 each cycle during a 1-word load -> word assembled correctly, single mem_we_o pulse.
REQ-036 length_i=33 with MEMORY_DEPTH=32 -> no mem_we_o, done_o=1, error_o=1 next cycle.
REQ-037 Reset asserted after 2 bytes of word 0 -> all outputs 0 immediately; new start then loads word 0 at 0x00400000.
REQ-038 start_i pulsed mid-load -> ignored; load completes with original length.
REQ-039 With LOADER_CHECKSUM_EN: bytes 01,02,03,04 then checksum 0xF6 -> error_o=0; checksum 0xF7 -> error_o=1.
